// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between control unit and mul_div_unit
//
// Purpose: groups the request strobe, operands and result/handshake signals.
// Ports (all in the modports):
//   start, op_div, A, B           request side, driven by the master
//   HI, LO, busy, done,
//   div_by_zero                   result side, driven by the slave (mul_div_unit)
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op_div, A, B,
        input  HI, LO, busy, done, div_by_zero
    );

    modport slave (
        input  start, op_div, A, B,
        output HI, LO, busy, done, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle signed multiply/divide, one bit per clock
//
// Purpose: signed MUL (shift-and-add) and DIV (restoring) on operand
// magnitudes, sign fixed up in a final cycle, result split into HI/LO.
// Ports:
//   clock    rising-edge clock
//   clear_n  asynchronous active-low reset
//   bus      slave side of mul_div_unit_if (start/op_div/A/B in,
//            HI/LO/busy/done/div_by_zero out)
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           clear_n,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 op_div_q, op_div_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // MUL: product; DIV: {remainder, quotient}
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       trial;
    logic                 trial_ge;
    logic [WIDTH-1:0]     trial_diff;
    logic [WIDTH-1:0]     div_rem, div_quo;
    logic [2*WIDTH-1:0]   mul_acc;
    logic                 neg;

    // Magnitudes of the latched operands; MIN maps to 2^(WIDTH-1), which
    // still fits as an unsigned WIDTH-bit value.
    assign a_mag = a_q[WIDTH-1] ? -a_q : a_q;
    assign b_mag = b_q[WIDTH-1] ? -b_q : b_q;
    assign neg   = a_q[WIDTH-1] ^ b_q[WIDTH-1];

    // Restoring division step, dividend bits consumed MSB first.
    // The remainder is always below the divisor, so WIDTH bits hold it.
    assign trial      = {acc_q[2*WIDTH-1:WIDTH], a_mag[cnt_q]};
    assign trial_ge   = trial >= {1'b0, b_mag};
    assign trial_diff = WIDTH'(trial - {1'b0, b_mag});
    assign div_rem    = trial_ge ? trial_diff : trial[WIDTH-1:0];
    assign div_quo    = acc_q[WIDTH-1:0] | (trial_ge ? (WIDTH'(1) << cnt_q) : '0);

    // Shift-and-add, multiplier bits consumed MSB first.
    assign mul_acc = {acc_q[2*WIDTH-2:0], 1'b0}
                   + (b_mag[cnt_q] ? {{WIDTH{1'b0}}, a_mag} : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_div_d = op_div_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_div_d = bus.op_div;
                    a_d      = bus.A;
                    b_d      = bus.B;
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH - 1);
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d = op_div_q ? {div_rem, div_quo} : mul_acc;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                if (op_div_q) begin
                    if (b_q == '0) begin
                        // Divide by zero: CALC result is discarded.
                        lo_d  = '1;
                        hi_d  = a_q;
                        dbz_d = 1'b1;
                    end else begin
                        // Quotient truncates toward zero; remainder follows the dividend.
                        lo_d  = neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d  = a_q[WIDTH-1] ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                        dbz_d = 1'b0;
                    end
                end else begin
                    {hi_d, lo_d} = neg ? -acc_q : acc_q;
                    dbz_d        = 1'b0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_div_q <= op_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
    logic clock;
    logic clear_n;
    int   checks;
    int   fails;
    int   n;
    int   ndone;

    mul_div_unit_if #(.WIDTH(32)) bus_if ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called away from a clock edge; returns #1 after the accept edge.
    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus_if.start  = 1'b1;
        bus_if.op_div = op;
        bus_if.A      = a;
        bus_if.B      = b;
        @(posedge clock);
        #1;
        bus_if.start  = 1'b0;
        bus_if.op_div = ~op;
        bus_if.A      = 32'hDEAD_BEEF;
        bus_if.B      = 32'h1234_5678;
        chk("busy_after_accept", {31'b0, bus_if.busy}, 32'd1);
        chk("done_low_after_accept", {31'b0, bus_if.done}, 32'd0);
    endtask

    // Waits (bounded) for done; returns #1 after the done-raising edge.
    task automatic wait_done(input string tag, input int first_edge,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input logic exp_dbz);
        n = first_edge;
        while (bus_if.done !== 1'b1 && n < 60) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, 32'd33);
        chk({tag, "_HI"}, bus_if.HI, exp_hi);
        chk({tag, "_LO"}, bus_if.LO, exp_lo);
        chk({tag, "_dbz"}, {31'b0, bus_if.div_by_zero}, {31'b0, exp_dbz});
        chk({tag, "_busy"}, {31'b0, bus_if.busy}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        clear_n       = 1'b0;
        bus_if.start  = 1'b0;
        bus_if.op_div = 1'b0;
        bus_if.A      = '0;
        bus_if.B      = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_HI", bus_if.HI, 32'd0);
        chk("reset_LO", bus_if.LO, 32'd0);
        chk("reset_busy", {31'b0, bus_if.busy}, 32'd0);
        chk("reset_done", {31'b0, bus_if.done}, 32'd0);
        chk("reset_dbz", {31'b0, bus_if.div_by_zero}, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;

        // Each op is issued in the done cycle of the previous one.
        issue(1'b0, 32'd6, 32'd7);
        wait_done("mul_6x7", 0, 32'h0000_0000, 32'h0000_002A, 1'b0);
        issue(1'b0, 32'hFFFF_FFFD, 32'd5);
        wait_done("mul_m3x5", 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done("mul_minxmin", 0, 32'h4000_0000, 32'h0000_0000, 1'b0);
        issue(1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
        wait_done("mul_m7xm6", 0, 32'h0000_0000, 32'h0000_002A, 1'b0);
        issue(1'b1, 32'd17, 32'd5);
        wait_done("div_17_5", 0, 32'h0000_0002, 32'h0000_0003, 1'b0);
        issue(1'b1, 32'hFFFF_FFEF, 32'd5);
        wait_done("div_m17_5", 0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        issue(1'b1, 32'd17, 32'hFFFF_FFFB);
        wait_done("div_17_m5", 0, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_min_m1", 0, 32'h0000_0000, 32'h8000_0000, 1'b0);
        issue(1'b1, 32'd17, 32'd0);
        wait_done("div_17_0", 0, 32'h0000_0011, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 32'd2, 32'd2);
        wait_done("mul_2x2", 0, 32'h0000_0000, 32'h0000_0004, 1'b0);
        issue(1'b1, 32'd100, 32'd7);
        wait_done("div_100_7", 0, 32'h0000_0002, 32'h0000_000E, 1'b0);

        // Start pulse at cycle 10 of a MUL must be ignored.
        issue(1'b0, 32'd6, 32'd7);
        repeat (9) @(posedge clock);
        bus_if.start  = 1'b1;
        bus_if.op_div = 1'b1;
        bus_if.A      = 32'd100;
        bus_if.B      = 32'd100;
        @(posedge clock);
        #1;
        bus_if.start = 1'b0;
        wait_done("mul_ignored_start", 10, 32'h0000_0000, 32'h0000_002A, 1'b0);
        ndone = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus_if.done === 1'b1) ndone++;
        end
        chk("single_done_pulse", ndone, 32'd0);

        // Reset at cycle 15 of a DIV discards it.
        issue(1'b1, 32'd100, 32'd7);
        repeat (14) @(posedge clock);
        #5;
        clear_n = 1'b0;
        #1;
        chk("abort_HI", bus_if.HI, 32'd0);
        chk("abort_LO", bus_if.LO, 32'd0);
        chk("abort_busy", {31'b0, bus_if.busy}, 32'd0);
        chk("abort_done", {31'b0, bus_if.done}, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus_if.done === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        issue(1'b0, 32'd6, 32'd7);
        wait_done("mul_after_reset", 0, 32'h0000_0000, 32'h0000_002A, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
